// File: rtl/connection_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : connection_pkg
//  Purpose  : Shared constants and state encoding for the UART-driven Booth
//             multiplier demo (connection + uart_rx).
//  Contents : clock/baud constants, operand width, ASCII digit codes,
//             top-level FSM state enum.
//  Revision : 1.0 - initial release
// ============================================================================
package connection_pkg;

    localparam int CLK_FREQ     = 50_000_000;
    localparam int BAUD         = 9600;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int N            = 4;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        SEND    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with a 2-flop input synchronizer, start-bit
//             glitch rejection and framing-error drop.
//  Ports    : CLK     - system clock, rising edge
//             RST     - synchronous active-high reset
//             i_rx    - asynchronous serial input, idle high
//             o_data  - last received byte (valid with o_valid)
//             o_valid - one-clock pulse per correctly framed byte
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid
);

    localparam int c_CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t       r_state, w_state_next;
    logic            r_sync1, r_sync2, r_prev;
    logic [c_CW-1:0] r_cnt, w_cnt_next;
    logic [2:0]      r_bit, w_bit_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            r_valid, w_valid_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            // Synchronizer resets to the idle level so no false edge is seen.
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_valid_next = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_next = '0;
                // Edge-triggered so a line held low after a framing error
                // does not retrigger.
                if (r_prev && !r_sync2) begin
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_next = '0;
                    w_bit_next = '0;
                    w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_next   = '0;
                    w_shift_next = {r_sync2, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = RX_STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = RX_IDLE;
                    w_valid_next = r_sync2;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    assign o_data  = r_shift;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/connection.sv
`default_nettype none
// ============================================================================
//  Module   : connection
//  Purpose  : UART Booth multiplier demo. Collects 2N ASCII '0'/'1' digits
//             (A then B, MSB first), multiplies them as signed N-bit values
//             with radix-2 Booth, and transmits the 2N-bit product as ASCII
//             '0'/'1' characters, MSB first.
//  Ports    : CLK    - system clock, rising edge
//             RST    - synchronous active-high reset
//             RX_IN  - UART receive line, idle high
//             TX_OUT - UART transmit line, idle high
//  Revision : 1.0 - initial release
// ============================================================================
module connection #(
    parameter int CLK_FREQ     = connection_pkg::CLK_FREQ,
    parameter int BAUD         = connection_pkg::BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic CLK,
    input  logic RST,
    input  logic RX_IN,
    output logic TX_OUT
);

    import connection_pkg::N;
    import connection_pkg::ASCII_ZERO;
    import connection_pkg::ASCII_ONE;
    import connection_pkg::state_t;
    import connection_pkg::COLLECT;
    import connection_pkg::COMPUTE;
    import connection_pkg::SEND;

    localparam int c_DCW = $clog2(2 * N + 1);
    localparam int c_ITW = $clog2(N);
    localparam int c_BYW = $clog2(2 * N);
    localparam int c_TCW = $clog2(CLKS_PER_BIT + 1);

    localparam logic [c_TCW-1:0] c_BIT_LAST   = c_TCW'(CLKS_PER_BIT - 1);
    localparam logic [c_DCW-1:0] c_LAST_DIGIT = c_DCW'(2 * N - 1);
    localparam logic [c_DCW-1:0] c_A_DIGITS   = c_DCW'(N);
    localparam logic [c_ITW-1:0] c_LAST_ITER  = c_ITW'(N - 1);
    localparam logic [c_BYW-1:0] c_LAST_BYTE  = c_BYW'(2 * N - 1);
    localparam logic [3:0]       c_STOP_IDX   = 4'd9;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [7:0] w_rx_data;
    logic       w_rx_valid;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .CLK     (CLK),
        .RST     (RST),
        .i_rx    (RX_IN),
        .o_data  (w_rx_data),
        .o_valid (w_rx_valid)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           r_state, w_state_next;
    logic [c_DCW-1:0] r_digit_cnt;
    logic [N-1:0]     r_a, r_b;
    logic [N:0]       r_acc, r_m;
    logic [N-1:0]     r_q;
    logic             r_qm1;
    logic [c_ITW-1:0] r_iter;
    logic [2*N-1:0]   r_product;
    logic             r_tx;
    logic [c_TCW-1:0] r_tx_cnt;
    logic [3:0]       r_tx_bit;
    logic [c_BYW-1:0] r_tx_byte;

    // ------------------------------------------------------------------
    // Digit decode: anything other than '0'/'1' is ignored. Bytes that
    // arrive outside COLLECT are dropped here, not in the receiver, so
    // the receiver stays frame-aligned.
    // ------------------------------------------------------------------
    logic w_is_digit, w_digit, w_take_digit, w_last_digit;

    assign w_is_digit   = w_rx_valid && ((w_rx_data == ASCII_ZERO) || (w_rx_data == ASCII_ONE));
    assign w_digit      = (w_rx_data == ASCII_ONE);
    assign w_take_digit = (r_state == COLLECT) && w_is_digit;
    assign w_last_digit = w_take_digit && (r_digit_cnt == c_LAST_DIGIT);

    // ------------------------------------------------------------------
    // Booth step: add/subtract M by {Q[0], q_-1}, then arithmetic shift
    // of {acc, Q, q_-1}. acc is N+1 bits so M = -2^(N-1) cannot overflow.
    // ------------------------------------------------------------------
    logic [N:0]   w_sum, w_acc_sh;
    logic [N-1:0] w_q_sh;
    logic         w_last_iter;

    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
    end

    assign w_acc_sh    = {w_sum[N], w_sum[N:1]};
    assign w_q_sh      = {w_sum[0], r_q[N-1:1]};
    assign w_last_iter = (r_state == COMPUTE) && (r_iter == c_LAST_ITER);

    // ------------------------------------------------------------------
    // Transmit framing: frame bit 0 is start, 1..8 data LSB first, 9 stop.
    // ------------------------------------------------------------------
    logic             w_tx_bit_end, w_tx_done, w_tx_level;
    logic [c_BYW-1:0] w_prod_idx;
    logic [7:0]       w_tx_char;
    logic [9:0]       w_frame;

    assign w_tx_bit_end = (r_state == SEND) && (r_tx_cnt == c_BIT_LAST);
    assign w_tx_done    = w_tx_bit_end && (r_tx_bit == c_STOP_IDX) && (r_tx_byte == c_LAST_BYTE);
    assign w_prod_idx   = c_LAST_BYTE - r_tx_byte;
    assign w_tx_char    = r_product[w_prod_idx] ? ASCII_ONE : ASCII_ZERO;
    assign w_frame      = {1'b1, w_tx_char, 1'b0};
    assign w_tx_level   = w_frame[r_tx_bit];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: if (w_last_digit) w_state_next = COMPUTE;
            COMPUTE: if (w_last_iter)  w_state_next = SEND;
            SEND:    if (w_tx_done)    w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_digit_cnt <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_m         <= '0;
            r_q         <= '0;
            r_qm1       <= 1'b0;
            r_iter      <= '0;
            r_product   <= '0;
            r_tx        <= 1'b1;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_byte   <= '0;
        end else begin
            if (w_take_digit) begin
                if (r_digit_cnt < c_A_DIGITS) begin
                    r_a <= {r_a[N-2:0], w_digit};
                end else begin
                    r_b <= {r_b[N-2:0], w_digit};
                end
                r_digit_cnt <= r_digit_cnt + 1'b1;
            end

            // Booth init uses the final multiplier digit directly.
            if (w_last_digit) begin
                r_acc  <= '0;
                r_q    <= {r_b[N-2:0], w_digit};
                r_qm1  <= 1'b0;
                r_m    <= {r_a[N-1], r_a};
                r_iter <= '0;
            end

            if (r_state == COMPUTE) begin
                r_acc  <= w_acc_sh;
                r_q    <= w_q_sh;
                r_qm1  <= r_q[0];
                r_iter <= r_iter + 1'b1;
                if (w_last_iter) begin
                    r_product <= {w_acc_sh[N-1:0], w_q_sh};
                    r_tx_cnt  <= '0;
                    r_tx_bit  <= '0;
                    r_tx_byte <= '0;
                end
            end

            if (r_state == SEND) begin
                r_tx <= w_tx_level;
                if (w_tx_bit_end) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bit == c_STOP_IDX) begin
                        r_tx_bit  <= '0;
                        r_tx_byte <= r_tx_byte + 1'b1;
                    end else begin
                        r_tx_bit <= r_tx_bit + 1'b1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                if (w_tx_done) begin
                    r_digit_cnt <= '0;
                end
            end else begin
                r_tx <= 1'b1;
            end
        end
    end

    assign TX_OUT = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_connection.sv
`default_nettype none
// ============================================================================
//  Module   : tb_connection
//  Purpose  : Self-checking bench for connection. Runs with a short bit time
//             (CLK_FREQ=16, BAUD=1 -> 16 clocks per bit). Expected product
//             characters are pushed to a queue when operands are driven; a
//             background UART monitor collects transmitted frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_connection;

    localparam int CPB = 16;

    logic CLK   = 1'b0;
    logic RST   = 1'b1;
    logic RX_IN = 1'b1;
    logic TX_OUT;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_exp[$];
    logic [8:0] q_got[$];   // {stop, data[7:0]}

    connection #(
        .CLK_FREQ (CPB),
        .BAUD     (1)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .RX_IN  (RX_IN),
        .TX_OUT (TX_OUT)
    );

    always #5 CLK = ~CLK;

    // UART monitor on TX_OUT: detect start, sample mid-bit.
    initial begin : monitor
        logic [8:0] w;
        forever begin
            @(negedge CLK);
            if (!RST && TX_OUT === 1'b0) begin
                repeat (CPB / 2) @(negedge CLK);
                for (int i = 0; i < 9; i++) begin
                    repeat (CPB) @(negedge CLK);
                    w[i] = TX_OUT;
                end
                q_got.push_back(w);
            end
        end
    end

    // Global watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge CLK);
        RX_IN = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX_IN = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RX_IN = stop_bit;
        repeat (CPB) @(negedge CLK);
        RX_IN = 1'b1;
    endtask

    task automatic send_digits(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) send_byte(v[i] ? 8'h31 : 8'h30, 1'b1);
    endtask

    task automatic push_expected(input logic [3:0] a, input logic [3:0] b);
        int ia, ib, prod;
        ia = $signed(a);
        ib = $signed(b);
        prod = ia * ib;
        for (int i = 7; i >= 0; i--) q_exp.push_back(prod[i] ? 8'h31 : 8'h30);
    endtask

    task automatic wait_frames(input int n);
        for (int t = 0; t < 12 * CPB * n + 400 && q_got.size() < n; t++) @(negedge CLK);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx got %b required 1", TX_OUT);
        end
        RST = 1'b0;
        repeat (3 * CPB) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || q_got.size() != 0) begin
            errors++;
            $display("FAIL reset_idle got tx=%b frames=%0d required tx=1 frames=0", TX_OUT, q_got.size());
        end
    endtask

    task automatic test_basic;
        logic [7:0] e;
        logic [8:0] g;
        checks++;
        if (TX_OUT !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle_before got %b required 1", TX_OUT);
        end
        push_expected(4'b0011, 4'b1001);
        send_digits(4'b0011);
        send_digits(4'b1001);
        wait_frames(8);
        checks++;
        if (q_got.size() != 8) begin
            errors++;
            $display("FAIL basic_count got %0d required 8", q_got.size());
        end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_got.size() > 0) ? q_got.pop_front() : 9'h000;
            checks++;
            if (g !== {1'b1, e}) begin
                errors++;
                $display("FAIL basic_frame got %h required %h", g, {1'b1, e});
            end
        end
        repeat (4 * CPB) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || q_got.size() != 0) begin
            errors++;
            $display("FAIL basic_idle_after got tx=%b frames=%0d required tx=1 frames=0", TX_OUT, q_got.size());
        end
    endtask

    task automatic test_corners;
        logic [3:0] ta [3] = '{4'b1000, 4'b0111, 4'b1000};
        logic [3:0] tb [3] = '{4'b1000, 4'b0111, 4'b0111};
        logic [7:0] e;
        logic [8:0] g;
        for (int k = 0; k < 3; k++) begin
            push_expected(ta[k], tb[k]);
            send_digits(ta[k]);
            send_digits(tb[k]);
            wait_frames(8);
            checks++;
            if (q_got.size() != 8) begin
                errors++;
                $display("FAIL corner%0d_count got %0d required 8", k, q_got.size());
            end
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                g = (q_got.size() > 0) ? q_got.pop_front() : 9'h000;
                checks++;
                if (g !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL corner%0d_frame got %h required %h", k, g, {1'b1, e});
                end
            end
            q_got.delete();
            repeat (2 * CPB) @(negedge CLK);
        end
    endtask

    task automatic test_non_digits;
        logic [7:0] e;
        logic [8:0] g;
        push_expected(4'b0011, 4'b0010);
        send_byte(8'h41, 1'b1);
        send_digits(4'b0011);
        send_byte(8'h78, 1'b1);
        send_digits(4'b0010);
        wait_frames(8);
        checks++;
        if (q_got.size() != 8) begin
            errors++;
            $display("FAIL nondigit_count got %0d required 8", q_got.size());
        end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_got.size() > 0) ? q_got.pop_front() : 9'h000;
            checks++;
            if (g !== {1'b1, e}) begin
                errors++;
                $display("FAIL nondigit_frame got %h required %h", g, {1'b1, e});
            end
        end
        q_got.delete();
        repeat (2 * CPB) @(negedge CLK);
    endtask

    task automatic test_reset_mid_tx;
        logic [7:0] e;
        logic [8:0] g;
        push_expected(4'b0101, 4'b0011);
        send_digits(4'b0101);
        send_digits(4'b0011);
        wait_frames(2);
        for (int t = 0; t < 4 * CPB && TX_OUT !== 1'b0; t++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_tx got %b required 1", TX_OUT);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (30 * CPB) @(negedge CLK);
        checks++;
        if (q_got.size() != 3) begin
            errors++;
            $display("FAIL rstmid_frames got %0d required 3", q_got.size());
        end
        q_got.delete();
        q_exp.delete();
        push_expected(4'b0001, 4'b1111);
        send_digits(4'b0001);
        send_digits(4'b1111);
        wait_frames(8);
        checks++;
        if (q_got.size() != 8) begin
            errors++;
            $display("FAIL rstmid_after_count got %0d required 8", q_got.size());
        end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_got.size() > 0) ? q_got.pop_front() : 9'h000;
            checks++;
            if (g !== {1'b1, e}) begin
                errors++;
                $display("FAIL rstmid_after_frame got %h required %h", g, {1'b1, e});
            end
        end
        q_got.delete();
        repeat (2 * CPB) @(negedge CLK);
    endtask

    task automatic test_framing_glitch;
        logic [7:0] e;
        logic [8:0] g;
        push_expected(4'b0101, 4'b0110);
        send_byte(8'h30, 1'b1);
        send_byte(8'h31, 1'b1);
        // '1' with a low stop bit must not count as a digit.
        send_byte(8'h31, 1'b0);
        repeat (2 * CPB) @(negedge CLK);
        // Start pulse shorter than half a bit, then a real frame shortly after.
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (12) @(negedge CLK);
        send_byte(8'h30, 1'b1);
        send_byte(8'h31, 1'b1);
        send_digits(4'b0110);
        wait_frames(8);
        checks++;
        if (q_got.size() != 8) begin
            errors++;
            $display("FAIL frameglitch_count got %0d required 8", q_got.size());
        end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            g = (q_got.size() > 0) ? q_got.pop_front() : 9'h000;
            checks++;
            if (g !== {1'b1, e}) begin
                errors++;
                $display("FAIL frameglitch_frame got %h required %h", g, {1'b1, e});
            end
        end
        q_got.delete();
        repeat (2 * CPB) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_non_digits();
        test_framing_glitch();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
